avalon_arb2: RTL

Two-requester Avalon-MM arbiter for the convolution accelerator. It shares one Avalon master port, toward the DDR/PCIe-side bridge, between two internal requesters: port 0 is the feature/weight read engine and port 1 is the result write-back engine. It does round-robin arbitration at command granularity and locks the grant for the full length of a write burst. It routes returning read beats to the requester that issued the command, using an in-order tag FIFO.

---
 rtl/avalon_arb2.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/avalon_arb2.sv
// Two-requester Avalon-MM arbiter: round-robin command arbitration, write-burst
// grant lock, and in-order routing of read data through a tag FIFO.
module avalon_arb2 #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int BE_WIDTH    = 8,
    parameter int MAX_BSIZE   = 4,
    parameter int OUTST_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  avs0_ready,
    input  logic [ADDR_WIDTH-1:0] avs0_addr,
    input  logic                  avs0_read_req,
    input  logic                  avs0_write_req,
    input  logic [DATA_WIDTH-1:0] avs0_wdata,
    input  logic [BE_WIDTH-1:0]   avs0_be,
    input  logic [MAX_BSIZE-1:0]  avs0_size,
    output logic                  avs0_rdata_valid,
    output logic                  avs1_ready,
    input  logic [ADDR_WIDTH-1:0] avs1_addr,
    input  logic                  avs1_read_req,
    input  logic                  avs1_write_req,
    input  logic [DATA_WIDTH-1:0] avs1_wdata,
    input  logic [BE_WIDTH-1:0]   avs1_be,
    input  logic [MAX_BSIZE-1:0]  avs1_size,
    output logic                  avs1_rdata_valid,
    output logic [DATA_WIDTH-1:0] avs_rdata,
    input  logic                  avm_ready,
    output logic [ADDR_WIDTH-1:0] avm_addr,
    output logic [DATA_WIDTH-1:0] avm_wdata,
    output logic [BE_WIDTH-1:0]   avm_be,
    output logic                  avm_read_req,
    output logic                  avm_write_req,
    output logic [MAX_BSIZE-1:0]  avm_size,
    input  logic                  avm_rdata_valid,
    input  logic [DATA_WIDTH-1:0] avm_rdata,
    output logic                  err_unexp_rdata
);

    localparam int PTR_W = $clog2(OUTST_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [MAX_BSIZE-1:0] SIZE_ONE = MAX_BSIZE'(1'b1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_WBURST = 1'b1
    } state_t;

    // A burstcount of zero still returns one beat.
    function automatic logic [MAX_BSIZE-1:0] eff_size(input logic [MAX_BSIZE-1:0] size);
        if (size == {MAX_BSIZE{1'b0}}) begin
            eff_size = SIZE_ONE;
        end else begin
            eff_size = size;
        end
    endfunction

    state_t                 state_r, state_s;
    logic                   last_grant_r;
    logic                   lock_id_r, lock_id_s;
    logic [MAX_BSIZE-1:0]   beats_r, beats_s;
    logic [MAX_BSIZE-1:0]   rbeats_r;
    logic                   id_mem_r   [OUTST_DEPTH];
    logic [MAX_BSIZE-1:0]   size_mem_r [OUTST_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic                   err_r;

    logic full_s, empty_s;
    logic act0_s, act1_s, sel_s;
    logic sel_rd_s, sel_wr_s;
    logic rd_s, wr_s, grant_ready_s;
    logic rd_acc_s, wr_acc_s;
    logic head_id_s;
    logic [MAX_BSIZE-1:0] head_size_s;
    logic beat_s, last_beat_s, push_s, pop_s;

    // Requester selection: locked owner during a burst, else round-robin over
    // requesters that can actually issue (a read is ineligible when tags are full).
    always_comb begin
        full_s = (count_r == CNT_W'(OUTST_DEPTH));
        act0_s = avs0_write_req | (avs0_read_req & ~full_s);
        act1_s = avs1_write_req | (avs1_read_req & ~full_s);
        sel_s  = 1'b0;
        if (state_r == ST_WBURST) begin
            sel_s = lock_id_r;
        end else if (act0_s && act1_s) begin
            sel_s = ~last_grant_r;
        end else if (act1_s) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // Command pass-through from the selected requester to the master port.
    always_comb begin
        avm_addr      = sel_s ? avs1_addr  : avs0_addr;
        avm_wdata     = sel_s ? avs1_wdata : avs0_wdata;
        avm_be        = sel_s ? avs1_be    : avs0_be;
        avm_size      = sel_s ? avs1_size  : avs0_size;
        sel_rd_s      = sel_s ? avs1_read_req  : avs0_read_req;
        sel_wr_s      = sel_s ? avs1_write_req : avs0_write_req;
        rd_s          = 1'b0;
        wr_s          = 1'b0;
        grant_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wr_s          = sel_wr_s;
                rd_s          = sel_rd_s & ~sel_wr_s & ~full_s;
                grant_ready_s = avm_ready & ~(sel_rd_s & ~sel_wr_s & full_s);
            end
            ST_WBURST: begin
                wr_s          = sel_wr_s;
                rd_s          = 1'b0;
                grant_ready_s = avm_ready & sel_wr_s;
            end
            default: begin
                wr_s          = 1'b0;
                rd_s          = 1'b0;
                grant_ready_s = 1'b0;
            end
        endcase
        avm_write_req = ~reset & wr_s;
        avm_read_req  = ~reset & rd_s;
        avs0_ready    = ~reset & ~sel_s & grant_ready_s;
        avs1_ready    = ~reset & sel_s & grant_ready_s;
        rd_acc_s      = avm_read_req & avm_ready;
        wr_acc_s      = avm_write_req & avm_ready;
    end

    // Burst tracking: a multi-beat write locks the grant until its last beat.
    always_comb begin
        state_s   = state_r;
        beats_s   = beats_r;
        lock_id_s = lock_id_r;
        case (state_r)
            ST_IDLE: begin
                if (wr_acc_s && (avm_size > SIZE_ONE)) begin
                    state_s   = ST_WBURST;
                    beats_s   = avm_size - SIZE_ONE;
                    lock_id_s = sel_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WBURST: begin
                if (wr_acc_s) begin
                    beats_s = beats_r - SIZE_ONE;
                    if (beats_r == SIZE_ONE) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_WBURST;
                    end
                end else begin
                    state_s = ST_WBURST;
                end
            end
            default: begin
                state_s = ST_IDLE;
                beats_s = {MAX_BSIZE{1'b0}};
            end
        endcase
    end

    // Read return routing from the head of the tag FIFO.
    always_comb begin
        empty_s          = (count_r == {CNT_W{1'b0}});
        head_id_s        = id_mem_r[rd_ptr_r];
        head_size_s      = size_mem_r[rd_ptr_r];
        beat_s           = avm_rdata_valid & ~empty_s;
        last_beat_s      = (rbeats_r == (head_size_s - SIZE_ONE));
        pop_s            = beat_s & last_beat_s;
        push_s           = rd_acc_s;
        avs_rdata        = avm_rdata;
        avs0_rdata_valid = ~reset & beat_s & ~head_id_s;
        avs1_rdata_valid = ~reset & beat_s & head_id_s;
        err_unexp_rdata  = err_r;
    end

    // Arbitration and burst state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            lock_id_r    <= 1'b0;
            beats_r      <= {MAX_BSIZE{1'b0}};
        end else begin
            state_r   <= state_s;
            lock_id_r <= lock_id_s;
            beats_r   <= beats_s;
            if (rd_acc_s || wr_acc_s) begin
                last_grant_r <= sel_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Tag storage; contents are only meaningful below count_r, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            id_mem_r[wr_ptr_r]   <= sel_s;
            size_mem_r[wr_ptr_r] <= eff_size(avm_size);
        end
    end

    // Tag FIFO pointers, occupancy, head beat counter and unexpected-data flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            rbeats_r <= {MAX_BSIZE{1'b0}};
            err_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
            if (beat_s) begin
                rbeats_r <= last_beat_s ? {MAX_BSIZE{1'b0}} : (rbeats_r + SIZE_ONE);
            end
            if (avm_rdata_valid && empty_s) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule
